// File: rtl/rv32i_pipe_core.sv
// Five-stage in-order RV32I integer core (IF/ID/EX/MEM/WB) with interlock-only
// RAW handling, no forwarding, and branch/jump resolution in EX.

module rv32i_pipe_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);
   logic [31:0] regs [0:31];
   logic        wr_live;

   assign wr_live = wr_en && (wr_addr != 5'd0);

   // Write-through lets ID see the value WB commits at this same edge.
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == 5'd0) begin
         rs1_data = '0;
      end else if (wr_live && (wr_addr == rs1_addr)) begin
         rs1_data = wr_data;
      end
      rs2_data = regs[rs2_addr];
      if (rs2_addr == 5'd0) begin
         rs2_data = '0;
      end else if (wr_live && (wr_addr == rs2_addr)) begin
         rs2_data = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end
endmodule

module rv32i_pipe_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [31:0] pc_addr
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [31:0] pc_curr_q, pc_curr_d, pc_curr;

   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;

   logic        id_ex_valid_q, id_ex_valid_d;
   logic        id_ex_reg_write_q, id_ex_reg_write_d;
   logic [4:0]  id_ex_rd_q, id_ex_rd_d;
   logic [6:0]  id_ex_opcode_q, id_ex_opcode_d;
   logic [2:0]  id_ex_funct3_q, id_ex_funct3_d;
   logic        id_ex_alt_q, id_ex_alt_d;
   logic [31:0] id_ex_pc_q, id_ex_pc_d;
   logic [31:0] id_ex_rs1_q, id_ex_rs1_d;
   logic [31:0] id_ex_rs2_q, id_ex_rs2_d;
   logic [31:0] id_ex_imm_q, id_ex_imm_d;

   logic        ex_mem_valid_q, ex_mem_valid_d;
   logic        ex_mem_reg_write_q, ex_mem_reg_write_d;
   logic [4:0]  ex_mem_rd_q, ex_mem_rd_d;
   logic [31:0] ex_mem_result_q, ex_mem_result_d;

   logic        mem_wb_reg_write_q, mem_wb_reg_write_d;
   logic [4:0]  mem_wb_rd_q, mem_wb_rd_d;
   logic [31:0] mem_wb_result_q, mem_wb_result_d;

   logic        mem_wb_reg_write;
   logic [4:0]  mem_wb_rd;
   logic [31:0] wdata_wb;

   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [4:0]  rd_id, rs1_id, rs2_id;
   logic [31:0] imm_id, rs1_val, rs2_val;
   logic        uses_rs1, uses_rs2, rw_id;
   logic        hit_rs1, hit_rs2, stall;

   logic [31:0] alu_a, alu_b, alu_out, ex_result, ex_target;
   logic [4:0]  shamt;
   logic        br_taken, redirect;

   assign pc_curr          = pc_curr_q;
   assign pc_addr          = pc_curr;
   assign mem_wb_reg_write = mem_wb_reg_write_q;
   assign mem_wb_rd        = mem_wb_rd_q;
   assign wdata_wb         = mem_wb_result_q;

   assign ir     = if_id_instr_q;
   assign opcode = ir[6:0];
   assign rd_id  = ir[11:7];
   assign rs1_id = ir[19:15];
   assign rs2_id = ir[24:20];

   rv32i_pipe_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_id),
      .rs2_addr (rs2_id),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .wr_en    (mem_wb_reg_write),
      .wr_addr  (mem_wb_rd),
      .wr_data  (wdata_wb)
   );

   always_comb begin
      imm_id   = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      rw_id    = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            imm_id = {ir[31:12], 12'b0};
            rw_id  = 1'b1;
         end
         OP_JAL: begin
            imm_id = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            rw_id  = 1'b1;
         end
         OP_JALR, OP_IMM: begin
            imm_id   = {{20{ir[31]}}, ir[31:20]};
            uses_rs1 = 1'b1;
            rw_id    = 1'b1;
         end
         OP_BRANCH: begin
            imm_id   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_REG: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            rw_id    = 1'b1;
         end
         default: ;
      endcase
   end

   // No forwarding: MEM/WB producers are covered by regfile write-through.
   assign hit_rs1 = uses_rs1 && (rs1_id != 5'd0) &&
      ((id_ex_valid_q && id_ex_reg_write_q && (id_ex_rd_q == rs1_id)) ||
       (ex_mem_valid_q && ex_mem_reg_write_q && (ex_mem_rd_q == rs1_id)));
   assign hit_rs2 = uses_rs2 && (rs2_id != 5'd0) &&
      ((id_ex_valid_q && id_ex_reg_write_q && (id_ex_rd_q == rs2_id)) ||
       (ex_mem_valid_q && ex_mem_reg_write_q && (ex_mem_rd_q == rs2_id)));
   assign stall = if_id_valid_q && (hit_rs1 || hit_rs2);

   always_comb begin
      alu_a = id_ex_rs1_q;
      alu_b = (id_ex_opcode_q == OP_REG) ? id_ex_rs2_q : id_ex_imm_q;
      shamt = alu_b[4:0];
      case (id_ex_funct3_q)
         3'd0:    alu_out = (id_ex_opcode_q == OP_REG && id_ex_alt_q) ? alu_a - alu_b
                                                                      : alu_a + alu_b;
         3'd1:    alu_out = alu_a << shamt;
         3'd2:    alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
         3'd3:    alu_out = {31'b0, alu_a < alu_b};
         3'd4:    alu_out = alu_a ^ alu_b;
         3'd5:    alu_out = id_ex_alt_q ? 32'($signed(alu_a) >>> shamt) : alu_a >> shamt;
         3'd6:    alu_out = alu_a | alu_b;
         default: alu_out = alu_a & alu_b;
      endcase

      case (id_ex_funct3_q)
         3'd0:    br_taken = (id_ex_rs1_q == id_ex_rs2_q);
         3'd1:    br_taken = (id_ex_rs1_q != id_ex_rs2_q);
         3'd4:    br_taken = $signed(id_ex_rs1_q) <  $signed(id_ex_rs2_q);
         3'd5:    br_taken = $signed(id_ex_rs1_q) >= $signed(id_ex_rs2_q);
         3'd6:    br_taken = id_ex_rs1_q <  id_ex_rs2_q;
         3'd7:    br_taken = id_ex_rs1_q >= id_ex_rs2_q;
         default: br_taken = 1'b0;
      endcase

      ex_target = id_ex_pc_q + id_ex_imm_q;
      redirect  = 1'b0;
      case (id_ex_opcode_q)
         OP_LUI:    ex_result = id_ex_imm_q;
         OP_AUIPC:  ex_result = id_ex_pc_q + id_ex_imm_q;
         OP_JAL: begin
            ex_result = id_ex_pc_q + 32'd4;
            redirect  = id_ex_valid_q;
         end
         OP_JALR: begin
            ex_result = id_ex_pc_q + 32'd4;
            ex_target = (id_ex_rs1_q + id_ex_imm_q) & ~32'd1;
            redirect  = id_ex_valid_q;
         end
         OP_BRANCH: begin
            ex_result = '0;
            redirect  = id_ex_valid_q && br_taken;
         end
         OP_IMM, OP_REG: ex_result = alu_out;
         default:   ex_result = '0;
      endcase
   end

   always_comb begin
      if (redirect) begin
         pc_curr_d = ex_target;
      end else if (stall) begin
         pc_curr_d = pc_curr_q;
      end else begin
         pc_curr_d = pc_curr_q + 32'd4;
      end

      if_id_valid_d = 1'b1;
      if_id_pc_d    = pc_curr_q;
      if_id_instr_d = instr;
      if (redirect) begin
         if_id_valid_d = 1'b0;
         if_id_pc_d    = '0;
         if_id_instr_d = '0;
      end else if (stall) begin
         if_id_valid_d = if_id_valid_q;
         if_id_pc_d    = if_id_pc_q;
         if_id_instr_d = if_id_instr_q;
      end

      id_ex_valid_d     = if_id_valid_q;
      id_ex_reg_write_d = if_id_valid_q && rw_id;
      id_ex_rd_d        = rd_id;
      id_ex_opcode_d    = opcode;
      id_ex_funct3_d    = ir[14:12];
      id_ex_alt_d       = ir[30];
      id_ex_pc_d        = if_id_pc_q;
      id_ex_rs1_d       = rs1_val;
      id_ex_rs2_d       = rs2_val;
      id_ex_imm_d       = imm_id;
      if (redirect || stall || !if_id_valid_q) begin
         id_ex_valid_d     = 1'b0;
         id_ex_reg_write_d = 1'b0;
         id_ex_rd_d        = '0;
         id_ex_opcode_d    = '0;
         id_ex_funct3_d    = '0;
         id_ex_alt_d       = 1'b0;
         id_ex_pc_d        = '0;
         id_ex_rs1_d       = '0;
         id_ex_rs2_d       = '0;
         id_ex_imm_d       = '0;
      end

      ex_mem_valid_d     = id_ex_valid_q;
      ex_mem_reg_write_d = id_ex_valid_q && id_ex_reg_write_q;
      ex_mem_rd_d        = id_ex_rd_q;
      ex_mem_result_d    = ex_result;

      mem_wb_reg_write_d = ex_mem_valid_q && ex_mem_reg_write_q;
      mem_wb_rd_d        = ex_mem_rd_q;
      mem_wb_result_d    = ex_mem_result_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_curr_q          <= RESET_PC;
         if_id_valid_q      <= 1'b0;
         if_id_pc_q         <= '0;
         if_id_instr_q      <= '0;
         id_ex_valid_q      <= 1'b0;
         id_ex_reg_write_q  <= 1'b0;
         id_ex_rd_q         <= '0;
         id_ex_opcode_q     <= '0;
         id_ex_funct3_q     <= '0;
         id_ex_alt_q        <= 1'b0;
         id_ex_pc_q         <= '0;
         id_ex_rs1_q        <= '0;
         id_ex_rs2_q        <= '0;
         id_ex_imm_q        <= '0;
         ex_mem_valid_q     <= 1'b0;
         ex_mem_reg_write_q <= 1'b0;
         ex_mem_rd_q        <= '0;
         ex_mem_result_q    <= '0;
         mem_wb_reg_write_q <= 1'b0;
         mem_wb_rd_q        <= '0;
         mem_wb_result_q    <= '0;
      end else begin
         pc_curr_q          <= pc_curr_d;
         if_id_valid_q      <= if_id_valid_d;
         if_id_pc_q         <= if_id_pc_d;
         if_id_instr_q      <= if_id_instr_d;
         id_ex_valid_q      <= id_ex_valid_d;
         id_ex_reg_write_q  <= id_ex_reg_write_d;
         id_ex_rd_q         <= id_ex_rd_d;
         id_ex_opcode_q     <= id_ex_opcode_d;
         id_ex_funct3_q     <= id_ex_funct3_d;
         id_ex_alt_q        <= id_ex_alt_d;
         id_ex_pc_q         <= id_ex_pc_d;
         id_ex_rs1_q        <= id_ex_rs1_d;
         id_ex_rs2_q        <= id_ex_rs2_d;
         id_ex_imm_q        <= id_ex_imm_d;
         ex_mem_valid_q     <= ex_mem_valid_d;
         ex_mem_reg_write_q <= ex_mem_reg_write_d;
         ex_mem_rd_q        <= ex_mem_rd_d;
         ex_mem_result_q    <= ex_mem_result_d;
         mem_wb_reg_write_q <= mem_wb_reg_write_d;
         mem_wb_rd_q        <= mem_wb_rd_d;
         mem_wb_result_q    <= mem_wb_result_d;
      end
   end
endmodule

// File: tb/tb_rv32i_pipe_core.sv
// Bench for rv32i_pipe_core: directed hazard/branch/jump programs plus random
// forward-only programs, all compared against a sequential instruction-level model.

module tb_rv32i_pipe_core;
   localparam logic [6:0]  OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
   localparam logic [6:0]  OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr, pc_addr;

   always #5 clk = ~clk;

   rv32i_pipe_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk     (clk),
      .rst     (rst),
      .instr   (instr),
      .pc_addr (pc_addr)
   );

   logic [31:0] prog [0:63];
   int          prog_len = 0;

   assign instr = (int'(pc_addr[31:2]) < prog_len) ? prog[pc_addr[7:2]] : NOP;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [4:0]  wr_rd[$];
   logic [31:0] wr_data[$];
   logic [31:0] pc_trace[$];
   int          stall_cnt;
   logic [31:0] m_regs [0:31];
   logic [4:0]  exp_rd[$];
   logic [31:0] exp_data[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_REG};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], OP_BR};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm20;
      return {v[19:0], 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OP_JAL};
   endfunction

   // Instruction-at-a-time interpreter; pipeline timing is irrelevant here.
   task automatic model_run();
      logic [31:0] pc, ins, a, b, res, nxt, imm_i, imm_b, imm_u, imm_j;
      logic [2:0]  f3;
      logic        wr, take, alt;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      exp_rd.delete();
      exp_data.delete();
      pc = 32'h0;
      for (int s = 0; s < 1000; s++) begin
         if (int'(pc[31:2]) >= prog_len) break;
         ins   = prog[pc[7:2]];
         f3    = ins[14:12];
         alt   = ins[30];
         a     = m_regs[ins[19:15]];
         imm_i = {{20{ins[31]}}, ins[31:20]};
         imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         imm_u = {ins[31:12], 12'b0};
         imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         b     = (ins[6:0] == OP_REG) ? m_regs[ins[24:20]] : imm_i;
         nxt   = pc + 4;
         wr    = 1'b1;
         res   = '0;
         case (ins[6:0])
            OP_LUI:   res = imm_u;
            OP_AUIPC: res = pc + imm_u;
            OP_JAL:   begin res = pc + 4; nxt = pc + imm_j; end
            OP_JALR:  begin res = pc + 4; nxt = (a + imm_i) & 32'hFFFF_FFFE; end
            OP_BR: begin
               wr = 1'b0;
               b  = m_regs[ins[24:20]];
               case (f3)
                  3'd0: take = (a == b);
                  3'd1: take = (a != b);
                  3'd4: take = ($signed(a) < $signed(b));
                  3'd5: take = ($signed(a) >= $signed(b));
                  3'd6: take = (a < b);
                  3'd7: take = (a >= b);
                  default: take = 1'b0;
               endcase
               if (take) nxt = pc + imm_b;
            end
            OP_IMM, OP_REG: begin
               case (f3)
                  3'd0: res = (ins[6:0] == OP_REG && alt) ? a - b : a + b;
                  3'd1: res = a << b[4:0];
                  3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  3'd3: res = (a < b) ? 32'd1 : 32'd0;
                  3'd4: res = a ^ b;
                  3'd5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                  3'd6: res = a | b;
                  default: res = a & b;
               endcase
            end
            default: wr = 1'b0;
         endcase
         if (wr && ins[11:7] != 5'd0) begin
            m_regs[ins[11:7]] = res;
            exp_rd.push_back(ins[11:7]);
            exp_data.push_back(res);
         end
         pc = nxt;
      end
   endtask

   // Resets (discarding whatever is in flight), runs the loaded program and
   // compares write-back order and final register state with the model.
   task automatic run_program(input string name);
      int ncyc, nz, n;
      ncyc = 6 * prog_len + 30;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val({name, " rst_pc"}, pc_addr, 32'h0);
      check_val({name, " rst_wb"}, 32'(dut.mem_wb_reg_write), 32'h0);
      nz = 0;
      for (int r = 0; r < 32; r++) if (dut.u_regfile.regs[r] != 32'h0) nz++;
      check_val({name, " rst_regs_nonzero"}, nz, 0);
      wr_rd.delete();
      wr_data.delete();
      pc_trace.delete();
      stall_cnt = 0;
      rst = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (dut.mem_wb_reg_write && dut.mem_wb_rd != 5'd0) begin
            wr_rd.push_back(dut.mem_wb_rd);
            wr_data.push_back(dut.wdata_wb);
         end
         if (dut.stall) stall_cnt++;
         pc_trace.push_back(pc_addr);
      end
      check_val({name, " pc0"}, pc_trace[0], 32'h0);
      check_val({name, " pc1"}, pc_trace[1], 32'h4);
      check_val({name, " pc2"}, pc_trace[2], 32'h8);
      model_run();
      check_val({name, " wb_count"}, wr_rd.size(), exp_rd.size());
      n = (wr_rd.size() < exp_rd.size()) ? wr_rd.size() : exp_rd.size();
      for (int k = 0; k < n; k++) begin
         check_val($sformatf("%s wb%0d_rd", name, k), 32'(wr_rd[k]), 32'(exp_rd[k]));
         check_val($sformatf("%s wb%0d_data", name, k), wr_data[k], exp_data[k]);
      end
      for (int r = 0; r < 32; r++)
         check_val($sformatf("%s x%0d", name, r), dut.u_regfile.regs[r], m_regs[r]);
   endtask

   task automatic clear_prog();
      for (int k = 0; k < 64; k++) prog[k] = NOP;
   endtask

   function automatic logic [31:0] rand_instr(input int i);
      int rd, rs1, rs2, f3, k;
      logic [31:0] br_f3s;
      rd  = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      f3  = $urandom_range(0, 7);
      k   = $urandom_range(1, 4);
      br_f3s = 32'h0076_5410;
      case ($urandom_range(0, 9))
         0: return enc_u(int'($urandom() & 32'hFFFFF), rd, OP_LUI);
         1: return enc_u(int'($urandom() & 32'hFFFFF), rd, OP_AUIPC);
         2, 3: begin
            if (f3 == 1 || f3 == 5)
               return enc_i((($urandom_range(0, 1) == 1 && f3 == 5) ? 32'h400 : 32'h0)
                            | $urandom_range(0, 31), rs1, f3, rd, OP_IMM);
            return enc_i(int'($urandom() & 32'hFFF), rs1, f3, rd, OP_IMM);
         end
         4, 5: return enc_r((f3 == 0 || f3 == 5) ? 32 * $urandom_range(0, 1) : 0, rs2, rs1, f3, rd);
         6: return enc_b(4 * k, rs2, rs1, int'(br_f3s[4*$urandom_range(0, 5) +: 4]));
         7: return enc_j(4 * k, rd);
         8: return enc_i(4 * (i + k) + 2 * $urandom_range(0, 1), 0, 0, rd, OP_JALR);
         default: return {$urandom()} & 32'hFFFF_FF80
                         | {25'b0, ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b1110011};
      endcase
   endfunction

   initial begin
      logic [31:0] jump_pcs [0:13];
      int cnt3, x3_first, x3_second, seen;

      // Taken branch
      clear_prog();
      prog[0] = enc_i(1, 0, 0, 1, OP_IMM);
      prog[1] = enc_i(1, 0, 0, 2, OP_IMM);
      prog[2] = enc_b(8, 2, 1, 0);
      prog[3] = enc_i(5, 0, 0, 3, OP_IMM);
      prog[4] = enc_i(2, 0, 0, 3, OP_IMM);
      prog_len = 5;
      run_program("beq");
      check_val("beq x3", dut.u_regfile.regs[3], 32'd2);
      cnt3 = 0;
      foreach (wr_rd[k]) if (wr_rd[k] == 5'd3 && wr_data[k] == 32'd5) cnt3++;
      check_val("beq skipped_wb", cnt3, 0);
      check_val("beq refetch", pc_trace[7], 32'h10);
      check_val("beq after", pc_trace[8], 32'h14);

      // Not-taken branch: fall-through with no flush
      prog[2] = enc_b(8, 2, 1, 1);
      run_program("bne");
      x3_first = -1; x3_second = -1; seen = 0;
      foreach (wr_rd[k]) if (wr_rd[k] == 5'd3) begin
         if (seen == 0) x3_first = int'(wr_data[k]); else x3_second = int'(wr_data[k]);
         seen++;
      end
      check_val("bne x3_writes", seen, 2);
      check_val("bne x3_first", x3_first, 5);
      check_val("bne x3_second", x3_second, 2);
      check_val("bne no_flush", pc_trace[7], 32'h14);
      check_val("bne stalls", stall_cnt, 2);

      // RAW interlock
      clear_prog();
      prog[0] = enc_i(7, 0, 0, 1, OP_IMM);
      prog[1] = enc_r(0, 1, 1, 0, 2);
      prog_len = 2;
      run_program("raw");
      check_val("raw stalls", stall_cnt, 2);
      check_val("raw x2", dut.u_regfile.regs[2], 32'd14);

      // JAL / JALR with flushed slots
      clear_prog();
      prog[4] = enc_j(12, 5);
      prog[5] = enc_j(16, 0);
      prog[6] = enc_i(1, 0, 0, 11, OP_IMM);
      prog[7] = enc_i(0, 5, 0, 6, OP_JALR);
      prog[8] = enc_i(1, 0, 0, 12, OP_IMM);
      prog[9] = enc_i(9, 0, 0, 13, OP_IMM);
      prog_len = 10;
      run_program("jump");
      check_val("jump x5", dut.u_regfile.regs[5], 32'h14);
      check_val("jump x6", dut.u_regfile.regs[6], 32'h20);
      check_val("jump x11", dut.u_regfile.regs[11], 32'h0);
      check_val("jump x12", dut.u_regfile.regs[12], 32'h0);
      check_val("jump x13", dut.u_regfile.regs[13], 32'd9);
      jump_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
                   32'h1C, 32'h20, 32'h24, 32'h14, 32'h18, 32'h1C, 32'h24};
      for (int k = 0; k < 14; k++)
         check_val($sformatf("jump fetch%0d", k), pc_trace[k], jump_pcs[k]);

      // ALU corners and x0
      clear_prog();
      prog[0] = enc_u(32'h80000, 7, OP_LUI);
      prog[1] = enc_i(32'h404, 7, 5, 8, OP_IMM);
      prog[2] = enc_r(0, 7, 0, 3, 9);
      prog[3] = enc_i(5, 0, 0, 0, OP_IMM);
      prog_len = 4;
      run_program("alu");
      check_val("alu x8", dut.u_regfile.regs[8], 32'hF800_0000);
      check_val("alu x9", dut.u_regfile.regs[9], 32'd1);
      check_val("alu x0", dut.u_regfile.regs[0], 32'd0);

      // Random forward-only programs
      for (int p = 0; p < 25; p++) begin
         clear_prog();
         prog_len = 32;
         for (int i = 0; i < 32; i++) prog[i] = rand_instr(i);
         run_program($sformatf("rand%0d", p));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
